// File: rtl/ahb_slave_mem.sv
// AHB-Lite word memory responder: registered address phase, programmable
// wait states on OKAY data phases, two-cycle ERROR for bad transfers.
module ahb_slave_mem #(
  parameter int DEPTH       = 16,
  parameter int WAIT_STATES = 0
) (
  input  logic        hclk,
  input  logic        hresetn,
  input  logic        hsel,
  input  logic [31:0] haddr,
  input  logic        hwrite,
  input  logic [2:0]  hsize,
  input  logic [2:0]  hburst,
  input  logic [3:0]  hprot,
  input  logic [1:0]  htrans,
  input  logic        hmastlock,
  input  logic        hready,
  input  logic [31:0] hwdata,
  output logic        hreadyout,
  output logic        hresp,
  output logic [31:0] hrdata
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2} state_t;

  typedef struct packed {
    logic [IW-1:0] idx;
    logic [1:0]    off;
    logic [1:0]    size;
    logic          write;
  } phase_t;

  state_t                 state, state_nx;
  logic [2:0]             cnt, cnt_nx;
  phase_t                 ph;
  logic [DEPTH-1:0][31:0] mem;
  logic                   accept, bad, mis;
  logic [3:0]             be;
  logic                   unused_ok;

  assign unused_ok = ^{hburst, hprot, hmastlock, htrans[0]};

  // Outputs decode only the state register, so no input reaches them combinationally.
  assign hreadyout = (state != S_WAIT) && (state != S_ERR1);
  assign hresp     = (state == S_ERR1) || (state == S_ERR2);
  assign hrdata    = (state == S_DATA && !ph.write) ? mem[ph.idx] : '0;

  assign accept = hsel & hready & htrans[1] & hreadyout;

  always_comb begin
    mis = 1'b0;
    case (hsize)
      3'd1:    mis = haddr[0];
      3'd2:    mis = |haddr[1:0];
      default: mis = 1'b0;
    endcase
  end

  assign bad = ({2'b00, haddr[31:2]} >= 32'(DEPTH)) | (hsize > 3'd2) | mis;

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      S_WAIT: begin
        if (cnt == 3'd0) state_nx = S_DATA;
        else             cnt_nx   = cnt - 3'd1;
      end
      S_ERR1: state_nx = S_ERR2;
      default: begin
        // IDLE, DATA and ERR2 drive ready high: a new address may land here.
        state_nx = S_IDLE;
        if (accept) begin
          if (bad) state_nx = S_ERR1;
          else if (WAIT_STATES > 0) begin
            state_nx = S_WAIT;
            cnt_nx   = 3'(WAIT_STATES - 1);
          end else state_nx = S_DATA;
        end
      end
    endcase
  end

  always_comb begin
    be = 4'b1111;
    case (ph.size)
      2'd0:    be = 4'b0001 << ph.off;
      2'd1:    be = ph.off[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state <= S_IDLE;
      cnt   <= '0;
      ph    <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (accept) begin
        ph.idx   <= haddr[IW+1:2];
        ph.off   <= haddr[1:0];
        ph.size  <= hsize[1:0];
        ph.write <= hwrite;
      end
    end
  end

  // Commit lands on the edge ending DATA, so an overlapping read sees it.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) mem <= '0;
    else if (state == S_DATA && ph.write) begin
      for (int b = 0; b < 4; b++)
        if (be[b]) mem[ph.idx][8*b +: 8] <= hwdata[8*b +: 8];
    end
  end

endmodule

// File: tb/tb_ahb_slave_mem.sv
// Bench for ahb_slave_mem: two instances (0 and 3 wait states) checked each
// cycle against a transaction-level model, plus literal read-back checks.
module tb_ahb_slave_mem;

  logic        hclk = 1'b0;
  logic        hresetn = 1'b1;
  logic [1:0]  sel;
  logic [31:0] haddr, hwdata;
  logic        hwrite, hmastlock;
  logic [2:0]  hsize, hburst;
  logic [3:0]  hprot;
  logic [1:0]  htrans;
  logic [1:0]        rdy_w, rsp_w;
  logic [1:0][31:0]  rd_w;
  int errors = 0;
  int checks = 0;

  always #5 hclk = ~hclk;

  typedef struct {
    bit       rdy;
    bit       resp;
    bit       dat;
    bit       wr;
    int       idx;
    bit [3:0] lanes;
  } ent_t;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : gi
    localparam int W = (g == 0) ? 0 : 3;

    ahb_slave_mem #(.DEPTH(16), .WAIT_STATES(W)) dut (
      .hclk(hclk), .hresetn(hresetn), .hsel(sel[g]), .haddr(haddr),
      .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hprot(hprot),
      .htrans(htrans), .hmastlock(hmastlock), .hready(rdy_w[g]),
      .hwdata(hwdata), .hreadyout(rdy_w[g]), .hresp(rsp_w[g]), .hrdata(rd_w[g])
    );

    // Model: a queue of expected per-cycle responses for the transfer in flight.
    logic [31:0] mem_m [16];
    ent_t        q[$];

    initial begin
      ent_t        e, ne;
      logic [31:0] exp_rd;
      int          n, off;
      bit          bad;
      for (int i = 0; i < 16; i++) mem_m[i] = 32'h0;
      forever begin
        @(negedge hclk);
        if (!hresetn) begin
          q.delete();
          for (int i = 0; i < 16; i++) mem_m[i] = 32'h0;
        end
        if (q.size() > 0) e = q[0];
        else begin
          e.rdy = 1; e.resp = 0; e.dat = 0; e.wr = 0; e.idx = 0; e.lanes = 0;
        end
        exp_rd = (e.dat && !e.wr) ? mem_m[e.idx] : 32'h0;
        check(g == 0 ? "cycle_w0" : "cycle_w3", {rdy_w[g], rsp_w[g], rd_w[g]},
              {e.rdy, e.resp, exp_rd});
        if (hresetn) begin
          if (q.size() > 0) begin
            if (e.dat && e.wr)
              for (int k = 0; k < 4; k++)
                if (e.lanes[k]) mem_m[e.idx][8*k +: 8] = hwdata[8*k +: 8];
            void'(q.pop_front());
          end
          if (sel[g] && e.rdy && htrans[1]) begin
            n   = (hsize <= 3'd2) ? (1 << hsize) : 1;
            off = int'(haddr % 4);
            bad = ((haddr >> 2) >= 16) || (hsize > 3'd2) || ((haddr % n) != 0);
            ne.dat = 0; ne.wr = 0; ne.idx = 0; ne.lanes = 0;
            if (bad) begin
              ne.rdy = 0; ne.resp = 1; q.push_back(ne);
              ne.rdy = 1; ne.resp = 1; q.push_back(ne);
            end else begin
              ne.rdy = 0; ne.resp = 0;
              for (int w = 0; w < W; w++) q.push_back(ne);
              ne.rdy = 1; ne.dat = 1; ne.wr = hwrite; ne.idx = int'(haddr >> 2);
              for (int k = 0; k < n; k++) ne.lanes[(off + k) % 4] = 1'b1;
              q.push_back(ne);
            end
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge hclk);
    #2;
  endtask

  // Single non-pipelined transfer; returns the data/resp seen in the ready cycle.
  task automatic xfer(input int g, input bit wr, input logic [31:0] a,
                      input logic [2:0] sz, input logic [31:0] wd,
                      output logic [31:0] d, output logic r, output int low);
    int n;
    sel = '0; sel[g] = 1'b1;
    htrans = 2'b10; haddr = a; hwrite = wr; hsize = sz;
    step();
    sel = '0; htrans = 2'b00; hwdata = wd; low = 0;
    for (n = 0; n < 20; n++) begin
      @(negedge hclk);
      if (rdy_w[g]) break;
      low++;
    end
    if (n == 20) begin
      checks++; errors++;
      $display("FAIL xfer_timeout: got hreadyout low for 20 cycles expected completion");
    end
    d = rd_w[g];
    r = rsp_w[g];
    @(posedge hclk);
    #2;
  endtask

  task automatic rd_chk(input int g, input logic [31:0] a, input logic [31:0] exp,
                        input string nm);
    logic [31:0] d; logic r; int low;
    xfer(g, 0, a, 3'd2, 32'h0, d, r, low);
    check(nm, {r, d}, {1'b0, exp});
  endtask

  typedef struct {
    bit          s;
    logic [1:0]  t;
    bit          w;
    logic [31:0] a;
    logic [31:0] d;
    bit          c;
    logic [31:0] e;
  } cyc_t;

  initial begin
    logic [31:0] d; logic r; int low;
    cyc_t tbl[12];

    sel = '0; haddr = '0; hwdata = '0; hwrite = 0; hmastlock = 0;
    hsize = 3'd2; hburst = 3'd0; hprot = 4'h3; htrans = 2'b00;
    #1 hresetn = 1'b0;
    #2;
    check("reset_out_w0", {rdy_w[0], rsp_w[0], rd_w[0]}, {1'b1, 1'b0, 32'h0});
    check("reset_out_w3", {rdy_w[1], rsp_w[1], rd_w[1]}, {1'b1, 1'b0, 32'h0});
    repeat (2) @(posedge hclk);
    #2 hresetn = 1'b1;
    step();

    // Word write then read, byte and halfword merges
    xfer(0, 1, 32'h24, 3'd2, 32'h12345678, d, r, low);
    xfer(0, 0, 32'h24, 3'd2, 32'h0, d, r, low);
    check("word_rd", {r, d}, {1'b0, 32'h12345678});
    check("word_rd_nowait", low, 0);
    xfer(0, 1, 32'h25, 3'd0, 32'h0000AB00, d, r, low);
    rd_chk(0, 32'h24, 32'h1234AB78, "byte_merge");
    xfer(0, 1, 32'h26, 3'd1, 32'hBEEF0000, d, r, low);
    rd_chk(0, 32'h24, 32'hBEEFAB78, "half_merge");

    // Error responses: out of range, misaligned, oversized
    xfer(0, 0, 32'h40, 3'd2, 32'h0, d, r, low);
    check("err_range", {r, low}, {1'b1, 32'd1});
    xfer(0, 1, 32'h02, 3'd2, 32'hFFFFFFFF, d, r, low);
    check("err_misalign", {r, low}, {1'b1, 32'd1});
    xfer(0, 1, 32'h00, 3'd3, 32'hFFFFFFFF, d, r, low);
    check("err_size", r, 1'b1);
    rd_chk(0, 32'h00, 32'h0, "err_no_write");
    rd_chk(0, 32'h24, 32'hBEEFAB78, "err_mem_kept");

    // Burst with BUSY, write->read overlap, address held through ERR1 into ERR2
    tbl[0]  = '{1, 2'b10, 1, 32'h00, 32'h0,        0, 32'h0};
    tbl[1]  = '{1, 2'b11, 1, 32'h04, 32'h1,        0, 32'h0};
    tbl[2]  = '{1, 2'b01, 1, 32'h08, 32'h2,        0, 32'h0};
    tbl[3]  = '{1, 2'b11, 1, 32'h08, 32'hDEADDEAD, 0, 32'h0};
    tbl[4]  = '{1, 2'b11, 1, 32'h0C, 32'h3,        0, 32'h0};
    tbl[5]  = '{1, 2'b10, 1, 32'h30, 32'h4,        0, 32'h0};
    tbl[6]  = '{1, 2'b10, 0, 32'h30, 32'h600DCAFE, 0, 32'h0};
    tbl[7]  = '{1, 2'b10, 0, 32'h40, 32'h0,        1, 32'h600DCAFE};
    tbl[8]  = '{1, 2'b10, 0, 32'h24, 32'h0,        0, 32'h0};
    tbl[9]  = '{1, 2'b10, 0, 32'h24, 32'h0,        0, 32'h0};
    tbl[10] = '{0, 2'b00, 0, 32'h00, 32'h0,        1, 32'hBEEFAB78};
    tbl[11] = '{0, 2'b00, 0, 32'h00, 32'h0,        0, 32'h0};
    hsize = 3'd2;
    for (int i = 0; i < 12; i++) begin
      sel = {1'b0, tbl[i].s}; htrans = tbl[i].t; hwrite = tbl[i].w;
      haddr = tbl[i].a; hwdata = tbl[i].d;
      @(negedge hclk);
      if (tbl[i].c) check("pipe_rd", rd_w[0], tbl[i].e);
      @(posedge hclk);
      #2;
    end
    rd_chk(0, 32'h00, 32'h1, "burst_0");
    rd_chk(0, 32'h04, 32'h2, "burst_1");
    rd_chk(0, 32'h08, 32'h3, "burst_2");
    rd_chk(0, 32'h0C, 32'h4, "burst_3");

    // Three wait states
    xfer(1, 1, 32'h10, 3'd2, 32'hCAFEF00D, d, r, low);
    check("ws_wr_low", low, 3);
    xfer(1, 0, 32'h10, 3'd2, 32'h0, d, r, low);
    check("ws_rd", {r, d}, {1'b0, 32'hCAFEF00D});
    check("ws_rd_low", low, 3);

    // Reset in the middle of a write's wait states
    sel = 2'b10; htrans = 2'b10; haddr = 32'h14; hwrite = 1; hsize = 3'd2;
    step();
    sel = '0; htrans = 2'b00; hwdata = 32'h55;
    check("ws_in_wait", rdy_w[1], 1'b0);
    step();
    hresetn = 1'b0;
    #1;
    check("rst_async", {rdy_w[1], rsp_w[1], rd_w[1]}, {1'b1, 1'b0, 32'h0});
    step();
    hresetn = 1'b1;
    step();
    rd_chk(1, 32'h14, 32'h0, "rst_lost_write");
    rd_chk(1, 32'h10, 32'h0, "rst_clear_w3");
    rd_chk(0, 32'h24, 32'h0, "rst_clear_w0");

    repeat (2) step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
